tmds_decoder: RTL

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_pkg.sv | 25 ++
 rtl/tmds_symbol_decode.sv | 40 ++++
 rtl/tmds_decoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, lock FSM states and small helpers.
// Used by both the encoder and the decoder.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } tmds_state_e;

    // One flag per control token, bit index equals the decoded control code.
    function automatic logic [3:0] token_match(input logic [9:0] word);
        return {word == CTRL_TOKEN_11, word == CTRL_TOKEN_10,
                word == CTRL_TOKEN_01, word == CTRL_TOKEN_00};
    endfunction

    function automatic logic [3:0] next_offset(input logic [3:0] offset);
        return (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS word into a pixel byte or
// a control code.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] word_i,
    output logic [7:0] data_o,
    output logic [1:0] control_o,
    output logic       is_ctrl_o
);

    logic [3:0] match;
    logic [7:0] d;
    logic [7:0] q;

    always_comb begin
        match     = token_match(word_i);
        is_ctrl_o = |match;

        control_o = 2'b00;
        if (match[1]) begin
            control_o = 2'b01;
        end else if (match[2]) begin
            control_o = 2'b10;
        end else if (match[3]) begin
            control_o = 2'b11;
        end

        // Undo the DC-balance inversion, then the XOR/XNOR transition chain.
        d    = word_i[9] ? ~word_i[7:0] : word_i[7:0];
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = word_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end

        data_o = is_ctrl_o ? 8'h00 : q;
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: word alignment search on control-token runs, lock
// supervision, and a three-stage decode pipeline.
//
// state  | meaning
// SEARCH | scanning bit offsets for a run of CTRL_RUN consecutive tokens
// LOCKED | offset frozen; dropped after LOCK_TIMEOUT cycles with no token
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 16,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       locked_out,
    output logic [3:0] offset_out
);

    localparam int RUN_W = (CTRL_RUN > 1)       ? $clog2(CTRL_RUN)       : 1;
    localparam int TMR_W = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int GAP_W = (LOCK_TIMEOUT > 1)   ? $clog2(LOCK_TIMEOUT)   : 1;

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LOCK_TIMEOUT - 1);

    logic [9:0]  r0_q, r1_q;
    logic [19:0] window;
    logic [9:0]  w;
    logic [9:0]  w_q;
    logic [3:0]  flags_q;
    logic        tok;

    logic [7:0]  dec_data;
    logic [1:0]  dec_ctrl;
    logic        dec_is_ctrl;
    logic [7:0]  data_q;
    logic [1:0]  ctrl_q;
    logic        ve_q;

    tmds_state_e       state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [3:0]        offset_q, offset_d;
    logic              locked;

    // r1 holds the older word, so the window is a contiguous bit stream.
    assign window = {r0_q, r1_q};
    assign w      = 10'(window >> offset_q);
    assign tok    = |flags_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r0_q    <= '0;
            r1_q    <= '0;
            w_q     <= '0;
            flags_q <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            ve_q    <= 1'b0;
        end else begin
            r0_q    <= tmds_in;
            r1_q    <= r0_q;
            w_q     <= w;
            flags_q <= token_match(w);
            data_q  <= dec_data;
            ctrl_q  <= dec_ctrl;
            ve_q    <= ~dec_is_ctrl;
        end
    end

    tmds_symbol_decode u_symbol_decode (
        .word_i    (w_q),
        .data_o    (dec_data),
        .control_o (dec_ctrl),
        .is_ctrl_o (dec_is_ctrl)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= SEARCH;
            run_q    <= '0;
            timer_q  <= '0;
            gap_q    <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            offset_q <= offset_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        timer_d  = timer_q;
        gap_d    = gap_q;
        offset_d = offset_q;
        unique case (state_q)
            SEARCH: begin
                // A completed run wins over a simultaneous timer expiry.
                if (tok && (run_q == RUN_LAST)) begin
                    state_d = LOCKED;
                    run_d   = '0;
                    timer_d = '0;
                    gap_d   = '0;
                end else if (timer_q == TMR_LAST) begin
                    offset_d = next_offset(offset_q);
                    run_d    = '0;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    run_d   = tok ? run_q + RUN_W'(1) : '0;
                end
            end
            LOCKED: begin
                if (tok) begin
                    gap_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    state_d  = SEARCH;
                    offset_d = next_offset(offset_q);
                    run_d    = '0;
                    timer_d  = '0;
                    gap_d    = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        locked      = (state_q == LOCKED);
        locked_out  = locked;
        offset_out  = offset_q;
        data_out    = locked ? data_q : 8'h00;
        control_out = locked ? ctrl_q : 2'b00;
        ve_out      = locked ? ve_q   : 1'b0;
    end

endmodule
